// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined carry-lookahead add/sub unit.
//   op_e      : operation encoding (ADD/SUB/ADDC/SUBC)
//   sat_max() : largest signed value of a w-bit word (0111...1), zero-extended
//   sat_min() : smallest signed value of a w-bit word (1000...0), zero-extended
//   width_ok(): elaboration-time legality of a WIDTH/GROUP pair
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_SUBC = 2'd3
  } op_e;

  // Helpers return a fixed 64-bit container; callers size-cast to their width.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int w, input int g);
    return (g > 0) && (w >= g) && (w <= MAX_WIDTH) && ((w % g) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: one GROUP-bit carry-lookahead slice (purely combinational).
//   p   : per-bit propagate (a ^ b_eff)
//   g   : per-bit generate  (a & b_eff)
//   ci  : carry into the group
//   gp  : group propagate (all bits propagate)
//   gg  : group generate (group produces a carry with ci = 0)
//   sum : GROUP-bit sum for the given ci
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] sum
);

  logic [GROUP-1:0] c;
  logic             gen_acc;

  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p ^ c;
  end

  // Group generate is the carry the slice emits when fed with zero.
  always_comb begin
    gen_acc = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gen_acc = g[i] | (p[i] & gen_acc);
    end
    gg = gen_acc;
    gp = &p;
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead adder/subtractor.
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid/in_ready      : operand handshake (a, b, cin, op, sat)
//   out_valid/out_ready    : result handshake (s, cout, ovfl, zero, neg)
// Stage 1 registers operands plus per-group P/G; stage 2 resolves group
// carries, forms the sum, saturates and produces flags into the output
// register. in_ready depends combinationally on out_ready only.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and <= 64");
  end

  // ---------------- stage 1: operand conditioning ----------------
  op_e              op_q;
  logic [WIDTH-1:0] beff;
  logic             cin_eff;
  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [WIDTH-1:0] s1_sum_unused;

  assign op_q  = op_e'(op);
  assign beff  = b ^ {WIDTH{op[0]}};
  assign bit_p = a ^ beff;
  assign bit_g = a & beff;

  // SUBC uses cin directly as carry-not-borrow, same as ADDC.
  always_comb begin
    case (op_q)
      OP_ADD:  cin_eff = 1'b0;
      OP_SUB:  cin_eff = 1'b1;
      default: cin_eff = cin;
    endcase
  end

  // Group P/G come from the same slice used in stage 2; its sum is not needed here.
  for (genvar gi = 0; gi < NG; gi++) begin : g_s1_pg
    cla_group #(.GROUP(GROUP)) u_pg (
      .p   (bit_p[gi*GROUP +: GROUP]),
      .g   (bit_g[gi*GROUP +: GROUP]),
      .ci  (1'b0),
      .gp  (grp_p[gi]),
      .gg  (grp_g[gi]),
      .sum (s1_sum_unused[gi*GROUP +: GROUP])
    );
  end

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_beff_reg;
  logic [WIDTH-1:0] s1_p_reg;
  logic [NG-1:0]    s1_gp_reg;
  logic [NG-1:0]    s1_gg_reg;
  logic             s1_cin_reg;
  logic             s1_sat_reg;

  // ---------------- handshake ----------------
  logic out_valid_reg;
  logic adv2;
  logic adv1;

  assign adv2     = !out_valid_reg | out_ready;
  assign adv1     = !s1_valid_reg | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_beff_reg  <= '0;
      s1_p_reg     <= '0;
      s1_gp_reg    <= '0;
      s1_gg_reg    <= '0;
      s1_cin_reg   <= 1'b0;
      s1_sat_reg   <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg    <= a;
        s1_beff_reg <= beff;
        s1_p_reg    <= bit_p;
        s1_gp_reg   <= grp_p;
        s1_gg_reg   <= grp_g;
        s1_cin_reg  <= cin_eff;
        s1_sat_reg  <= sat;
      end
    end
  end

  // ---------------- stage 2: lookahead, sum, saturation ----------------
  logic [NG:0]      carry;
  logic [WIDTH-1:0] s2_bit_g;
  logic [WIDTH-1:0] raw;
  logic [NG-1:0]    s2_gp_unused;
  logic [NG-1:0]    s2_gg_unused;
  logic             ovfl_raw;
  logic [WIDTH-1:0] s_final;

  assign carry[0] = s1_cin_reg;
  assign s2_bit_g = s1_a_reg & s1_beff_reg;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s2
    assign carry[gi+1] = s1_gg_reg[gi] | (s1_gp_reg[gi] & carry[gi]);

    cla_group #(.GROUP(GROUP)) u_sum (
      .p   (s1_p_reg[gi*GROUP +: GROUP]),
      .g   (s2_bit_g[gi*GROUP +: GROUP]),
      .ci  (carry[gi]),
      .gp  (s2_gp_unused[gi]),
      .gg  (s2_gg_unused[gi]),
      .sum (raw[gi*GROUP +: GROUP])
    );
  end

  // Overflow compares against the effective B so subtraction is handled too.
  assign ovfl_raw = (s1_a_reg[MSB] == s1_beff_reg[MSB]) & (raw[MSB] != s1_a_reg[MSB]);

  // On overflow both operands share a's sign, so a's sign picks the clamp rail.
  always_comb begin
    s_final = raw;
    if (s1_sat_reg && ovfl_raw) begin
      s_final = s1_a_reg[MSB] ? SAT_MIN : SAT_MAX;
    end
  end

  // ---------------- output register ----------------
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovfl_reg;
  logic             zero_reg;
  logic             neg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovfl_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s_reg    <= s_final;
        cout_reg <= carry[NG];
        ovfl_reg <= ovfl_raw;
        zero_reg <= (s_final == '0);
        neg_reg  <= s_final[MSB];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign cout      = cout_reg;
  assign ovfl      = ovfl_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed bench driving a 16/4 and a 32/8 instance in
// lockstep with the same control and width-matched operands.
module tb_cla_addsub_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, cin, sat, out_ready;
  logic [1:0]  op;
  logic [15:0] a16, b16, s16;
  logic [31:0] a32, b32, s32;
  logic        in_ready16, out_valid16, cout16, ovfl16, zero16, neg16;
  logic        in_ready32, out_valid32, cout32, ovfl32, zero32, neg32;
  logic [3:0]  f16, f32;

  assign f16 = {cout16, ovfl16, zero16, neg16};
  assign f32 = {cout32, ovfl32, zero32, neg32};

  int checks = 0;
  int errors = 0;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid16), .out_ready(out_ready), .s(s16),
    .cout(cout16), .ovfl(ovfl16), .zero(zero16), .neg(neg16)
  );

  cla_addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid32), .out_ready(out_ready), .s(s32),
    .cout(cout32), .ovfl(ovfl32), .zero(zero32), .neg(neg32)
  );

  // Presents one beat for exactly one rising edge; returns on the following negedge.
  task automatic drive_beat(input logic [1:0] o, input logic st, input logic ci,
                            input logic [15:0] x16, input logic [15:0] y16,
                            input logic [31:0] x32, input logic [31:0] y32);
    op = o; sat = st; cin = ci;
    a16 = x16; b16 = y16; a32 = x32; b32 = y32;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'd0; sat = 1'b0; cin = 1'b0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== 21'd0) begin
      errors++;
      $display("FAIL reset16: got v=%0b s=%h f=%b, expected v=0 s=0000 f=0000", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== 37'd0) begin
      errors++;
      $display("FAIL reset32: got v=%0b s=%h f=%b, expected v=0 s=00000000 f=0000", out_valid32, s32, f32);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready16, in_ready32, out_valid16, out_valid32} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0b%0b v=%0b%0b, expected rdy=11 v=00",
               in_ready16, in_ready32, out_valid16, out_valid32);
    end
    $display("reset: out_valid=%0b/%0b in_ready=%0b/%0b", out_valid16, out_valid32, in_ready16, in_ready32);
  endtask

  task automatic test_add_ovfl();
    drive_beat(OP_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 32'h7FFF_FFFF, 32'h1);
    checks++;
    if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin
      errors++;
      $display("FAIL add_ovfl_early: got v=%0b/%0b one cycle after accept, expected 0/0", out_valid16, out_valid32);
    end
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h8000, 4'b0101}) begin
      errors++;
      $display("FAIL add_ovfl16: got v=%0b s=%h f=%b, expected v=1 s=8000 f=0101", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h8000_0000, 4'b0101}) begin
      errors++;
      $display("FAIL add_ovfl32: got v=%0b s=%h f=%b, expected v=1 s=80000000 f=0101", out_valid32, s32, f32);
    end
    $display("add_ovfl: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
  endtask

  task automatic test_add_sat();
    drive_beat(OP_ADD, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h7FFF, 4'b0100}) begin
      errors++;
      $display("FAIL add_sat16: got v=%0b s=%h f=%b, expected v=1 s=7fff f=0100", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h7FFF_FFFF, 4'b0100}) begin
      errors++;
      $display("FAIL add_sat32: got v=%0b s=%h f=%b, expected v=1 s=7fffffff f=0100", out_valid32, s32, f32);
    end
    $display("add_sat: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
  endtask

  task automatic test_sub();
    drive_beat(OP_SUB, 1'b0, 1'b1, 16'h0000, 16'h0001, 32'h0, 32'h1);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'hFFFF, 4'b0001}) begin
      errors++;
      $display("FAIL sub_borrow16: got v=%0b s=%h f=%b, expected v=1 s=ffff f=0001", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'hFFFF_FFFF, 4'b0001}) begin
      errors++;
      $display("FAIL sub_borrow32: got v=%0b s=%h f=%b, expected v=1 s=ffffffff f=0001", out_valid32, s32, f32);
    end
    $display("sub_borrow: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
    drive_beat(OP_SUB, 1'b1, 1'b0, 16'h8000, 16'h0001, 32'h8000_0000, 32'h1);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h8000, 4'b1101}) begin
      errors++;
      $display("FAIL sub_sat16: got v=%0b s=%h f=%b, expected v=1 s=8000 f=1101", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h8000_0000, 4'b1101}) begin
      errors++;
      $display("FAIL sub_sat32: got v=%0b s=%h f=%b, expected v=1 s=80000000 f=1101", out_valid32, s32, f32);
    end
    $display("sub_sat: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
  endtask

  task automatic test_carry_ops();
    drive_beat(OP_ADDC, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h0000, 4'b1010}) begin
      errors++;
      $display("FAIL addc16: got v=%0b s=%h f=%b, expected v=1 s=0000 f=1010", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h0, 4'b1010}) begin
      errors++;
      $display("FAIL addc32: got v=%0b s=%h f=%b, expected v=1 s=00000000 f=1010", out_valid32, s32, f32);
    end
    $display("addc: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
    drive_beat(OP_SUBC, 1'b0, 1'b0, 16'h0005, 16'h0003, 32'h5, 32'h3);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h0001, 4'b1000}) begin
      errors++;
      $display("FAIL subc16: got v=%0b s=%h f=%b, expected v=1 s=0001 f=1000", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h1, 4'b1000}) begin
      errors++;
      $display("FAIL subc32: got v=%0b s=%h f=%b, expected v=1 s=00000001 f=1000", out_valid32, s32, f32);
    end
    $display("subc: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
    // Carries ripple across every group boundary.
    drive_beat(OP_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FCD, 32'h1234_5678, 32'h0FCD_A988);
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16} !== {1'b1, 16'h2201, 4'b0000}) begin
      errors++;
      $display("FAIL chain16: got v=%0b s=%h f=%b, expected v=1 s=2201 f=0000", out_valid16, s16, f16);
    end
    checks++;
    if ({out_valid32, s32, f32} !== {1'b1, 32'h2202_0000, 4'b0000}) begin
      errors++;
      $display("FAIL chain32: got v=%0b s=%h f=%b, expected v=1 s=22020000 f=0000", out_valid32, s32, f32);
    end
    $display("chain: s16=%h s32=%h flags=%b/%b", s16, s32, f16, f32);
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    bit          saw_full = 1'b0;
    bit          held = 1'b0;
    logic [15:0] hold16 = '0;
    logic [31:0] hold32 = '0;
    @(negedge clk);
    for (int c = 0; c < 30 && got < 5; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 5);
      op = OP_ADD; sat = 1'b0; cin = 1'b0;
      a16 = sent[15:0]; b16 = 16'h1000; a32 = sent; b32 = 32'h1000_0000;
      #1;
      if (held) begin
        checks++;
        if (s16 !== hold16 || s32 !== hold32) begin
          errors++;
          $display("FAIL stall_hold: got s=%h/%h, expected held s=%h/%h", s16, s32, hold16, hold32);
        end
      end
      held = 1'b0;
      if (out_valid16 && !out_ready) begin
        held = 1'b1; hold16 = s16; hold32 = s32;
      end
      if (in_valid && !in_ready16 && !in_ready32) saw_full = 1'b1;
      if (out_valid16 && out_ready) begin
        checks++;
        if (out_valid32 !== 1'b1 || s16 !== (16'h1000 + got[15:0]) || s32 !== (32'h1000_0000 + got)) begin
          errors++;
          $display("FAIL stream_order: result %0d got s=%h/%h v32=%0b, expected s=%h/%h v32=1",
                   got, s16, s32, out_valid32, 16'h1000 + got[15:0], 32'h1000_0000 + got);
        end
        $display("stream: result %0d s16=%h s32=%h", got, s16, s32);
        got++;
      end
      if (in_valid && in_ready16) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 5 || sent != 5) begin
      errors++;
      $display("FAIL stream_count: got %0d results from %0d beats, expected 5 from 5", got, sent);
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL stream_full: in_ready never dropped while stalled, expected a drop");
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    op = OP_ADD; sat = 1'b0; cin = 1'b0;
    a16 = 16'h0011; b16 = 16'h0011; a32 = 32'h11; b32 = 32'h11;
    in_valid = 1'b1;
    @(negedge clk);
    a16 = 16'h0022; a32 = 32'h22;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid16, s16, out_valid32, s32} !== 50'd0) begin
      errors++;
      $display("FAIL midflight_reset: got v=%0b/%0b s=%h/%h, expected v=0/0 s=0/0",
               out_valid16, out_valid32, s16, s32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid16, out_valid32, in_ready16, in_ready32} !== 4'b0011) begin
      errors++;
      $display("FAIL after_reset: got v=%0b%0b rdy=%0b%0b, expected v=00 rdy=11",
               out_valid16, out_valid32, in_ready16, in_ready32);
    end
    drive_beat(OP_ADD, 1'b0, 1'b0, 16'h0003, 16'h0004, 32'h3, 32'h4);
    checks++;
    if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: got v=%0b/%0b, expected 0/0", out_valid16, out_valid32);
    end
    @(negedge clk);
    checks++;
    if ({out_valid16, s16, f16, out_valid32, s32, f32} !==
        {1'b1, 16'h0007, 4'b0000, 1'b1, 32'h7, 4'b0000}) begin
      errors++;
      $display("FAIL post_reset_beat: got v=%0b/%0b s=%h/%h f=%b/%b, expected v=1/1 s=0007/00000007 f=0000/0000",
               out_valid16, out_valid32, s16, s32, f16, f32);
    end
    $display("post_reset: s16=%h s32=%h", s16, s32);
  endtask

  initial begin
    test_reset();
    test_add_ovfl();
    test_add_sat();
    test_sub();
    test_carry_ops();
    test_back_to_back();
    test_reset_midflight();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
